// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control.
// Each stage resolves BLK_PER_STAGE skip blocks from the carry registered by the previous stage.
module cska_pipe #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned BLOCK         = 4,
  parameter int unsigned BLK_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SLICE  = BLOCK * BLK_PER_STAGE;
  localparam int unsigned STAGES = WIDTH / SLICE;

  if (WIDTH % BLOCK != 0) begin : g_bad_block
    $error("cska_pipe: WIDTH must be a multiple of BLOCK");
  end
  if (WIDTH % SLICE != 0) begin : g_bad_stage
    $error("cska_pipe: WIDTH must be a multiple of BLOCK*BLK_PER_STAGE");
  end

  logic [STAGES-1:0]            v_q, v_d, c_q, c_d, cm_q, cm_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;

  // Per-stage inputs: stage 0 sees conditioned operands, later stages see the previous rank.
  logic [STAGES-1:0]            st_v, st_c;
  logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_sum;

  logic en;
  logic unused_ops;

  assign en       = !v_q[STAGES-1] || out_ready;
  assign in_ready = en;

  // Operands are zeroed for bubbles so nothing unknown enters an invalid slot.
  always_comb begin
    st_v   = '0;
    st_c   = '0;
    st_a   = '0;
    st_b   = '0;
    st_sum = '0;
    st_v[0] = in_valid;
    if (in_valid) begin
      st_a[0] = a;
      st_b[0] = sub ? ~b : b;
      st_c[0] = cin ^ sub;
    end
    for (int unsigned s = 1; s < STAGES; s++) begin
      st_v[s]   = v_q[s-1];
      st_c[s]   = c_q[s-1];
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_sum[s] = sum_q[s-1];
    end
  end

  always_comb begin
    logic             c, bc, p, x, cm;
    logic [WIDTH-1:0] sm;
    int unsigned      idx;
    v_d   = st_v;
    a_d   = st_a;
    b_d   = st_b;
    c_d   = '0;
    cm_d  = '0;
    sum_d = '0;
    c     = 1'b0;
    bc    = 1'b0;
    p     = 1'b0;
    x     = 1'b0;
    cm    = 1'b0;
    sm    = '0;
    idx   = 0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      c  = st_c[s];
      sm = st_sum[s];
      cm = 1'b0;
      for (int unsigned k = 0; k < BLK_PER_STAGE; k++) begin
        bc = c;
        p  = 1'b1;
        for (int unsigned i = 0; i < BLOCK; i++) begin
          idx     = (s * BLK_PER_STAGE + k) * BLOCK + i;
          x       = st_a[s][idx] ^ st_b[s][idx];
          sm[idx] = x ^ bc;
          if (idx == WIDTH - 1) cm = bc;
          bc      = (st_a[s][idx] & st_b[s][idx]) | (x & bc);
          p       = p & x;
        end
        // Fully propagating block forwards its carry-in past the ripple chain.
        c = p ? c : bc;
      end
      c_d[s]   = c;
      cm_d[s]  = cm;
      sum_d[s] = sm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      cm_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else if (en) begin
      v_q   <= v_d;
      c_q   <= c_d;
      cm_q  <= cm_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  // Consumed operand slices and early carry-into-MSB ranks are left for synthesis to prune.
  assign unused_ops = ^{a_q, b_q, cm_q};

  assign out_valid = v_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = c_q[STAGES-1] ^ cm_q[STAGES-1];

endmodule

// File: tb/tb_cska_pipe.sv
// Directed bench for cska_pipe (16-bit, 4-bit blocks, 4 stages) with an in-order
// scoreboard of {cout, ovf, sum} expectations.
module tb_cska_pipe;

  localparam int unsigned W = 16;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  // Directed vectors; expectation packed as {cout, ovf, sum}.
  logic [W-1:0] va [8] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFF80,
                           16'h0005, 16'h0003, 16'h8000, 16'h0005};
  logic [W-1:0] vb [8] = '{16'h0000, 16'h0001, 16'h8000, 16'hFF80,
                           16'h0003, 16'h0005, 16'h0001, 16'h0003};
  logic         vc [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic         vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [W+1:0] ve [8] = '{{2'b10, 16'h0000}, {2'b01, 16'h8000}, {2'b11, 16'h0000},
                           {2'b10, 16'hFF00}, {2'b10, 16'h0002}, {2'b00, 16'hFFFE},
                           {2'b11, 16'h7FFF}, {2'b10, 16'h0001}};

  logic [W-1:0] ra [8];
  logic [W-1:0] rb [8];
  logic         rc [8];
  logic         rs [8];

  cska_pipe #(
    .WIDTH        (W),
    .BLOCK        (4),
    .BLK_PER_STAGE(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Golden model via wide addition; overflow from the operand/result sign rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         o;
    be = ms ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, mc ^ ms};
    o  = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
    return {t[W], o, t[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(mon_e[W-1:0]));
        chk("cout", 32'(cout), 32'(mon_e[W+1]));
        chk("ovf", 32'(ovf), 32'(mon_e[W]));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
    sub      = 1'bx;
  endtask

  // Presents operands until accepted; returns 1 time unit after the accepting edge.
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic ts, input logic [W+1:0] e);
    bit ok;
    int n;
    ok       = 1'b0;
    n        = 0;
    a        = ta;
    b        = tb;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) exp_q.push_back(e);
      cycle();
      n++;
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'(1));
  endtask

  task automatic check_latency(input string tag, input logic [W-1:0] es);
    for (int e = 1; e <= 3; e++) begin
      chk({tag, "_early_valid"}, 32'(out_valid), 32'(0));
      cycle();
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'(0));
    cycle();
    chk("no_extra_result", 32'(out_valid), 32'(0));
  endtask

  initial begin
    idle();
    repeat (2) cycle();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));

    drive(16'd2, 16'd3, 1'b0, 1'b0, {2'b00, 16'h0005});
    idle();
    check_latency("lat_2p3", 16'h0005);
    drain();

    for (int i = 0; i < 8; i++) drive(va[i], vb[i], vc[i], vs[i], ve[i]);
    idle();
    drain();

    for (int i = 0; i < 8; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        out_ready = 1'b0;
        a         = ra[i];
        b         = rb[i];
        cin       = rc[i];
        sub       = rs[i];
        in_valid  = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'(0));
          chk("stall_out_valid", 32'(out_valid), 32'(1));
          chk("stall_sum", 32'(sum), 32'(exp_q[0][W-1:0]));
          chk("stall_cout", 32'(cout), 32'(exp_q[0][W+1]));
          cycle();
        end
        out_ready = 1'b1;
      end
      drive(ra[i], rb[i], rc[i], rs[i], model(ra[i], rb[i], rc[i], rs[i]));
    end
    idle();
    drain();

    for (int i = 0; i < 3; i++) drive(16'(i + 10), 16'(i), 1'b0, 1'b0, 18'(2 * i + 10));
    idle();
    cycle();
    chk("pre_rst_out_valid", 32'(out_valid), 32'(1));
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'(0));
    chk("async_rst_sum", 32'(sum), 32'(0));
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("post_rst_stale", 32'(out_valid), 32'(0));
    end
    drive(16'd127, 16'd127, 1'b0, 1'b0, {2'b00, 16'd254});
    idle();
    check_latency("lat_127", 16'd254);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
